// File: rtl/sig_capture_pkg.sv
// sig_capture_pkg
//   Shared types and default sizing for the sig_capture slice.
//   state_t          : capture FSM states (IDLE, ARMED, CAPTURE, DONE)
//   DATA_W_DEF       : default sample width per channel
//   ADDR_W_DEF       : default buffer address width (depth = 2**ADDR_W)
//   PRE_SAMPLES_DEF  : default pre-trigger sample count
package sig_capture_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int ADDR_W_DEF      = 8;
  localparam int PRE_SAMPLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// capture_ram
//   Two-channel sample store: one write port carrying {ch1,ch2}, one
//   synchronous read port with 1-cycle latency. Read-during-write to the
//   same address returns the previous contents. The array itself is not
//   reset; only the read register is cleared by rst.
//   Ports:
//     clk    : clock
//     rst    : asynchronous active-low reset (read register only)
//     we     : write enable
//     waddr  : write address
//     wdata  : write data {ch1, ch2}
//     raddr  : read address
//     rdata  : registered read data {ch1, ch2}
module capture_ram
  import sig_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [2*DATA_W-1:0] rdata
);

  logic [2*DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register samples the array before this edge's write lands,
  // giving old-data semantics on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sig_capture.sv
// sig_capture
//   Two-channel triggered capture. Channel 1 is the trigger source: a
//   rising crossing of 'level' (previous sample below, current at or
//   above) while ARMED starts the capture. The trigger sample is stored
//   and counted as the first post-trigger sample; DONE is entered on the
//   edge that writes the last one. arm restarts from any state.
//
//   Optional feature macro SIGCAP_PRETRIG_EN: when defined, ARMED writes
//   every sample circularly, triggers are ignored until PRE_SAMPLES have
//   been collected, and the post-trigger length is 2**ADDR_W-PRE_SAMPLES.
//   When undefined, nothing is written in ARMED, the trigger sample lands
//   at address 0 and 2**ADDR_W samples are captured.
//
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset
//     en         : sample strobe, din1/din2 valid when high
//     din1       : channel-1 sample (trigger source)
//     din2       : channel-2 sample
//     arm        : single-cycle start/restart
//     level      : unsigned trigger threshold
//     rd_addr    : readout address
//     rd_data1/2 : stored samples at the previous cycle's rd_addr
//     busy       : ARMED or CAPTURE
//     done       : DONE
//     trig_addr  : buffer address of the trigger sample
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int PRE_SAMPLES = PRE_SAMPLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic              arm,
  input  logic [DATA_W-1:0] level,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

`ifdef SIGCAP_PRETRIG_EN
  localparam bit PRETRIG = 1'b1;
`else
  localparam bit PRETRIG = 1'b0;
`endif

  localparam int PRE_EFF  = PRETRIG ? PRE_SAMPLES : 0;
  localparam int POST_CNT = DEPTH - PRE_EFF;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]    post_cnt;
  logic [DATA_W-1:0]   prev_din1;
  logic                prev_valid;
  logic                pre_ok;
  logic                crossing;
  logic                trig;
  logic                we;
  logic                last;
  logic [2*DATA_W-1:0] rdata;

`ifdef SIGCAP_PRETRIG_EN
  logic [CNT_W-1:0] fill_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          fill_cnt <= '0;
    else if (arm)                      fill_cnt <= '0;
    else if (en && (state == ARMED))   fill_cnt <= sat_inc(fill_cnt);
  end

  assign pre_ok = (fill_cnt >= CNT_W'(PRE_EFF));
`else
  assign pre_ok = 1'b1;
`endif

  // Qualify trigger and write; arm always takes priority over both.
  assign crossing = prev_valid && (prev_din1 < level) && (din1 >= level);
  assign trig     = (state == ARMED) && en && !arm && pre_ok && crossing;
  assign we       = en && !arm &&
                    ((state == CAPTURE) || ((state == ARMED) && (PRETRIG || trig)));
  assign last     = (state == CAPTURE) && en && !arm &&
                    (post_cnt == CNT_W'(POST_CNT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = ARMED;
    end else begin
      case (state)
        ARMED:   if (trig) state_nxt = (POST_CNT == 1) ? DONE : CAPTURE;
        CAPTURE: if (last) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state == ARMED) || (state == CAPTURE);
    done = (state == DONE);
  end

  // Capture bookkeeping: pointer, post-trigger count, edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      post_cnt   <= '0;
      prev_din1  <= '0;
      prev_valid <= 1'b0;
      trig_addr  <= '0;
    end else if (arm) begin
      wr_ptr     <= '0;
      post_cnt   <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (trig) begin
        post_cnt  <= CNT_W'(1);
        trig_addr <= wr_ptr;
      end else if (we && (state == CAPTURE)) begin
        post_cnt <= post_cnt + 1'b1;
      end
      if (en && ((state == ARMED) || (state == CAPTURE))) begin
        prev_din1  <= din1;
        prev_valid <= 1'b1;
      end
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr),
    .wdata ({din1, din2}),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  assign rd_data1 = rdata[2*DATA_W-1:DATA_W];
  assign rd_data2 = rdata[DATA_W-1:0];

endmodule
